// File: rtl/merge2x1_rr.sv
// Two-input valid/ready merge with round-robin, packet-locked arbitration.
// Output is a single registered stage; out_sel tags the source port of each beat.
module merge2x1_rr #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_last,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sel,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                       state;
    logic                         rr_ptr;
    logic                         load_en;
    logic                         gnt_vld;
    logic                         gnt;
    logic                         acc;
    logic [1:0]                   vld;
    logic [1:0]                   lst;
    logic [1:0][DATA_WIDTH-1:0]   dat;

    assign vld = {in1_valid, in0_valid};
    assign lst = {in1_last, in0_last};
    assign dat = {in1_data, in0_data};

    always_comb begin
        load_en = !out_valid || out_ready;
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        case (state)
            LOCK0: begin gnt_vld = 1'b1; gnt = 1'b0; end
            LOCK1: begin gnt_vld = 1'b1; gnt = 1'b1; end
            default: begin
                if (vld[0] && vld[1]) begin
                    gnt_vld = 1'b1;
                    gnt     = rr_ptr;
                end else if (vld[0]) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b0;
                end else if (vld[1]) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end
            end
        endcase
        // A locked port that is not valid simply stalls; the other port never sneaks in.
        acc       = !reset && load_en && gnt_vld && vld[gnt];
        in0_ready = acc && !gnt;
        in1_ready = acc && gnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (load_en) begin
                out_valid <= acc;
                if (acc) begin
                    out_data <= dat[gnt];
                    out_sel  <= gnt;
                    out_last <= lst[gnt];
                end
            end
            if (acc) begin
                if (lst[gnt]) begin
                    state  <= IDLE;
                    rr_ptr <= ~gnt;
                end else begin
                    state  <= gnt ? LOCK1 : LOCK0;
                end
            end
        end
    end

endmodule
